// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the transmitter, receiver and the
// top-level test designs.
//   OVERSAMPLE       - baud-generator ticks per bit period
//   DEF_DBIT         - default data bits per frame
//   DEF_SB_TICK      - default stop length in oversample ticks (16 = 1 stop bit)
//   DEF_DVSR         - default clocks per oversample tick (50 MHz / (16 x 19200))
//   tx_state_e       - transmitter FSM state encoding
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;
  localparam int DEF_DVSR    = 163;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: start/ready/done handshake between a byte source
// (FIFO read side or message sequencer) and the UART transmitter.
//   tx_start     - source requests a send of din (honoured only while tx_ready)
//   din          - byte to send, latched on the accept cycle
//   tx_ready     - transmitter idle and able to accept
//   tx_done_tick - one-cycle pulse in the last cycle of the stop period
// Modports: master = byte source, slave = transmitter.
interface uart_tx_serializer_if
  import uart_pkg::*;
#(
  parameter int DBIT = DEF_DBIT
);

  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            tx_ready;
  logic            tx_done_tick;

  modport master (
    output tx_start,
    output din,
    input  tx_ready,
    input  tx_done_tick
  );

  modport slave (
    input  tx_start,
    input  din,
    output tx_ready,
    output tx_done_tick
  );

endinterface

// File: rtl/uart_tx_serializer_baud_gen.sv
// baud_gen: free-running mod-M counter producing the oversample tick.
//   clk        - system clock
//   reset      - synchronous active-high reset
//   i_clr      - synchronous clear, restarts the count at 0
//   o_max_tick - high while the count equals M-1 (one cycle in every M)
module baud_gen
  import uart_pkg::*;
#(
  parameter int M = DEF_DVSR
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_max_tick
);

  localparam int            W    = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0]  LAST = W'(M - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_max_tick = (r_count == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1-style UART transmitter with its own baud generator.
//   clk    - system clock
//   reset  - synchronous active-high reset; aborts any frame, tx returns high
//   tx_if  - start/ready/done handshake (slave side)
//   tx     - registered serial output, idle high, LSB first
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | line high, tx_ready=1, waiting for tx_start
// START   | start bit (line low) for OVERSAMPLE ticks
// DATA    | shift[0] on the line, DBIT bits of OVERSAMPLE ticks each
// STOP    | line high for SB_TICK ticks, done pulse in the last cycle
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK,
  parameter int DVSR    = DEF_DVSR
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_tx_serializer_if.slave   tx_if,
  output logic                  tx
);

  localparam int TW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

  tx_state_e       r_state, w_state_next;
  logic [TW-1:0]   r_n, w_n_next;
  logic [BW-1:0]   r_b, w_b_next;
  logic [DBIT-1:0] r_shift, w_shift_next;
  logic            r_tx, w_tx_next;
  logic            w_accept;
  logic            w_s_tick;
  logic            w_done;

  assign w_accept = (r_state == ST_IDLE) && tx_if.tx_start;

  // Clearing the divider on accept makes every frame's timing start from the
  // accept edge, regardless of where the free-running count happened to be.
  baud_gen #(
    .M (DVSR)
  ) u_baud_gen (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_accept),
    .o_max_tick (w_s_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_n     <= '0;
      r_b     <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_n     <= w_n_next;
      r_b     <= w_b_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_n_next     = r_n;
    w_b_next     = r_b;
    w_shift_next = r_shift;
    w_done       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (tx_if.tx_start) begin
          w_state_next = ST_START;
          w_n_next     = '0;
          w_shift_next = tx_if.din;
        end
      end
      ST_START: begin
        if (w_s_tick) begin
          if (r_n == OS_LAST) begin
            w_state_next = ST_DATA;
            w_n_next     = '0;
            w_b_next     = '0;
          end else begin
            w_n_next = r_n + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_s_tick) begin
          if (r_n == OS_LAST) begin
            w_n_next     = '0;
            w_shift_next = {1'b0, r_shift[DBIT-1:1]};
            if (r_b == BIT_LAST) begin
              w_state_next = ST_STOP;
            end else begin
              w_b_next = r_b + 1'b1;
            end
          end else begin
            w_n_next = r_n + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_s_tick) begin
          if (r_n == SB_LAST) begin
            w_state_next = ST_IDLE;
            w_n_next     = '0;
            w_done       = 1'b1;
          end else begin
            w_n_next = r_n + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // The line level is derived from the next state so tx is a pure register
  // output that moves on the same edge as the state, only at bit boundaries.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      ST_START: w_tx_next = 1'b0;
      ST_DATA:  w_tx_next = w_shift_next[0];
      default:  w_tx_next = 1'b1;
    endcase
  end

  assign tx                 = r_tx;
  assign tx_if.tx_ready     = (r_state == ST_IDLE);
  assign tx_if.tx_done_tick = w_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic tx_a, tx_b, tx_c;

  uart_tx_serializer_if #(.DBIT(8)) ifa ();
  uart_tx_serializer_if #(.DBIT(7)) ifb ();
  uart_tx_serializer_if #(.DBIT(8)) ifc ();

  uart_tx_serializer #(.DBIT(8), .SB_TICK(16), .DVSR(4)) dut_a (
    .clk(clk), .reset(reset), .tx_if(ifa), .tx(tx_a));
  uart_tx_serializer #(.DBIT(7), .SB_TICK(32), .DVSR(4)) dut_b (
    .clk(clk), .reset(reset), .tx_if(ifb), .tx(tx_b));
  uart_tx_serializer dut_c (
    .clk(clk), .reset(reset), .tx_if(ifc), .tx(tx_c));

  int checks = 0;
  int failures = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // which DUT the monitor watches, and that DUT's frame parameters
  int sel = 0;
  int mon_dvsr = 4, mon_dbit = 8, mon_sb = 16;
  logic m_tx, m_ready, m_done;

  always_comb begin
    case (sel)
      1:       begin m_tx = tx_b; m_ready = ifb.tx_ready; m_done = ifb.tx_done_tick; end
      2:       begin m_tx = tx_c; m_ready = ifc.tx_ready; m_done = ifc.tx_done_tick; end
      default: begin m_tx = tx_a; m_ready = ifa.tx_ready; m_done = ifa.tx_done_tick; end
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // scoreboard
  logic [7:0] exp_q[$];
  int fall_cyc[$];
  int frames = 0, done_total = 0, last_len = 0, last_rise = 0;

  // Reference line level k cycles after the start-bit fall.
  function automatic logic exp_level(int kk, logic [7:0] b, int dvsr, int dbit);
    int p;
    p = 16 * dvsr;
    if (kk < p) return 1'b0;
    if (kk < p * (1 + dbit)) return b[(kk / p) - 1];
    return 1'b1;
  endfunction

  bit in_frame = 0, has_exp = 0;
  logic prev_tx = 1'b1;
  int k, f_len, werr, first_rise;
  logic [7:0] cur_exp, dec;

  always @(negedge clk) begin
    int p;
    p = 16 * mon_dvsr;
    if (m_done === 1'b1) done_total++;
    if (reset) begin
      in_frame = 0;
    end else begin
      if (!in_frame && prev_tx === 1'b1 && m_tx === 1'b0) begin
        in_frame = 1; k = 0; werr = 0; first_rise = -1; dec = 8'h00;
        f_len = (16 * (1 + mon_dbit) + mon_sb) * mon_dvsr;
        fall_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++; failures++; has_exp = 0; cur_exp = 8'h00;
          $display("FAIL unexpected_frame actual=frame_started required=no_frame cycle=%0d", cyc);
        end else begin
          has_exp = 1; cur_exp = exp_q.pop_front();
        end
      end
      if (in_frame) begin
        if (k < f_len) begin
          if (m_tx !== exp_level(k, cur_exp, mon_dvsr, mon_dbit)) werr++;
          if (m_ready !== 1'b0) werr++;
          if (m_done !== (k == f_len - 1)) werr++;
          if (first_rise < 0 && m_tx === 1'b1) first_rise = k;
          if (k >= p && k < p * (1 + mon_dbit) && (k % p) == p / 2) dec[k / p - 1] = m_tx;
        end else if (m_ready === 1'b1 || k >= f_len + 8) begin
          if (has_exp) check("frame_data", int'(dec), int'(cur_exp));
          check("frame_wave_errs", werr, 0);
          check("frame_len", (m_ready === 1'b1) ? k : -1, f_len);
          last_len = (m_ready === 1'b1) ? k : -1;
          last_rise = first_rise;
          frames++;
          in_frame = 0;
        end
        k++;
      end
    end
    prev_tx = m_tx;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int s, logic v, logic [7:0] d);
    case (s)
      1:       begin ifb.tx_start = v; ifb.din = d[6:0]; end
      2:       begin ifc.tx_start = v; ifc.din = d; end
      default: begin ifa.tx_start = v; ifa.din = d; end
    endcase
  endtask

  function automatic logic get_ready(int s);
    case (s)
      1:       return ifb.tx_ready;
      2:       return ifc.tx_ready;
      default: return ifa.tx_ready;
    endcase
  endfunction

  task automatic send(int s, logic [7:0] d);
    int t;
    t = 0;
    while (!get_ready(s) && t < 2000) begin tick(); t++; end
    if (!get_ready(s)) check("send_ready_timeout", 0, 1);
    drive(s, 1'b1, d);
    exp_q.push_back((s == 1) ? (d & 8'h7F) : d);
    tick();
    drive(s, 1'b0, d);
  endtask

  task automatic wait_frames(int target, int budget, string name);
    int t;
    t = 0;
    while (frames < target && t < budget) begin tick(); t++; end
    check(name, frames, target);
  endtask

  task automatic use_dut(int s, int dvsr, int dbit, int sb);
    sel = s; mon_dvsr = dvsr; mon_dbit = dbit; mon_sb = sb;
  endtask

  initial begin
    int f0, d0, n0, acc, t;
    logic pr;
    logic [7:0] rb;

    reset = 1'b1;
    drive(0, 1'b0, 8'h00); drive(1, 1'b0, 8'h00); drive(2, 1'b0, 8'h00);
    repeat (3) tick();

    // reset wins over tx_start
    drive(0, 1'b1, 8'h55);
    tick();
    check("rst_tx_a", int'(tx_a), 1);
    check("rst_ready_a", int'(ifa.tx_ready), 1);
    check("rst_done_a", int'(ifa.tx_done_tick), 0);
    check("rst_tx_b", int'(tx_b), 1);
    check("rst_ready_b", int'(ifb.tx_ready), 1);
    check("rst_tx_c", int'(tx_c), 1);
    check("rst_ready_c", int'(ifc.tx_ready), 1);
    drive(0, 1'b0, 8'h00);
    reset = 1'b0;
    repeat (3) tick();
    check("idle_tx_a", int'(tx_a), 1);

    // single 0x55 frame
    use_dut(0, 4, 8, 16);
    d0 = done_total; f0 = frames;
    send(0, 8'h55);
    wait_frames(f0 + 1, 800, "t1_frames");
    check("t1_len", last_len, 640);
    check("t1_start_low", last_rise, 64);
    check("t1_done_count", done_total - d0, 1);

    // tx_start held for three back-to-back 0xA3 frames
    d0 = done_total; f0 = frames; n0 = fall_cyc.size();
    repeat (3) exp_q.push_back(8'hA3);
    drive(0, 1'b1, 8'hA3);
    acc = 0; t = 0; pr = 1'b1;
    while (acc < 3 && t < 3000) begin
      tick(); t++;
      if (pr && !ifa.tx_ready) acc++;
      pr = ifa.tx_ready;
    end
    drive(0, 1'b0, 8'hA3);
    check("t2_accepts", acc, 3);
    wait_frames(f0 + 3, 2500, "t2_frames");
    check("t2_done_count", done_total - d0, 3);
    if (fall_cyc.size() >= n0 + 3) begin
      check("t2_gap_1", fall_cyc[n0 + 1] - fall_cyc[n0], 641);
      check("t2_gap_2", fall_cyc[n0 + 2] - fall_cyc[n0 + 1], 641);
    end else begin
      check("t2_fall_count", fall_cyc.size() - n0, 3);
    end

    // disturbance during the data phase of a 0x0F frame
    f0 = frames;
    send(0, 8'h0F);
    repeat (200) tick();
    drive(0, 1'b1, 8'hFF);
    tick();
    drive(0, 1'b0, 8'hFF);
    repeat (100) tick();
    drive(0, 1'b1, 8'hFF);
    tick();
    drive(0, 1'b0, 8'hFF);
    wait_frames(f0 + 1, 800, "t3_frames");
    repeat (60) tick();
    check("t3_no_second_frame", frames, f0 + 1);
    check("t3_ready", int'(ifa.tx_ready), 1);

    // reset during data bit 3, then a clean 0x81 frame
    send(0, 8'hC3);
    repeat (280) tick();
    d0 = done_total;
    reset = 1'b1;
    tick();
    check("t4_tx_after_rst", int'(tx_a), 1);
    check("t4_ready_after_rst", int'(ifa.tx_ready), 1);
    reset = 1'b0;
    repeat (5) tick();
    check("t4_no_done", done_total - d0, 0);
    f0 = frames;
    send(0, 8'h81);
    wait_frames(f0 + 1, 800, "t4_frames");
    check("t4_done_count", done_total - d0, 1);

    // 7 data bits, 2 stop bits
    use_dut(1, 4, 7, 32);
    f0 = frames;
    send(1, 8'h41);
    wait_frames(f0 + 1, 800, "t5_frames");
    check("t5_len", last_len, 640);

    // randomized bytes with random gaps
    use_dut(0, 4, 8, 16);
    f0 = frames;
    for (int i = 0; i < 5; i++) begin
      rb = 8'($urandom_range(0, 255));
      send(0, rb);
      repeat ($urandom_range(0, 700)) tick();
    end
    wait_frames(f0 + 5, 3500, "t7_frames");

    // default parameters at 19200 baud / 50 MHz
    use_dut(2, 163, 8, 16);
    f0 = frames;
    send(2, 8'h0D);
    wait_frames(f0 + 1, 27000, "t6_frames");
    check("t6_bit_period", last_rise, 2608);
    check("t6_len", last_len, 26080);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
